// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
// Accepts one instruction word plus PC per valid/ready handshake. It decodes the
// register indices, the sign-extended immediate, the ALU operation, the control
// flags and an illegal flag, and holds the result in one output register that
// supports back-pressure and flush.
// Build option: define DECODE_RV32M_EN to accept the RV32M multiply/divide group
// (OP with funct7 = 0000001). When it is left undefined, that group is illegal.
// Ports:
//   clk, rst (async, active-high), flush
//   in_valid / in_ready (comb), in_instruction[31:0], in_pc[XLEN-1:0]
//   out_valid / out_ready, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm,
//   out_alu_op[4:0], out_alu_src_imm, out_alu_src_pc, out_reg_write,
//   out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_alu_src_pc,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  // funct3 to ALU code; alt selects SUB/SRA.
  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            legal, rw, src_imm, src_pc, mr, mw, br, jp;
  logic [XLEN-1:0] imm;
  logic [4:0]      alu_op;
  bundle_t         dec;
  bundle_t         bundle_d, bundle_q;
  logic            valid_d, valid_q;
  logic            accept;

  assign opcode = in_instruction[6:0];
  assign f3     = in_instruction[14:12];
  assign f7     = in_instruction[31:25];

  // Immediate formats, sign-extended from inst[31].
  assign imm_i = XLEN'($signed(in_instruction[31:20]));
  assign imm_s = XLEN'($signed({in_instruction[31:25], in_instruction[11:7]}));
  assign imm_b = XLEN'($signed({in_instruction[31], in_instruction[7],
                                in_instruction[30:25], in_instruction[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instruction[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instruction[31], in_instruction[19:12],
                                in_instruction[20], in_instruction[30:21], 1'b0}));

  // Opcode decode and legality.
  always_comb begin
    legal   = 1'b0;
    imm     = '0;
    alu_op  = ALU_ADD;
    src_imm = 1'b0;
    src_pc  = 1'b0;
    rw      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    br      = 1'b0;
    jp      = 1'b0;
    case (opcode)
      OPC_LUI:      begin legal = 1'b1; imm = imm_u; alu_op = ALU_PASSB; src_imm = 1'b1; rw = 1'b1; end
      OPC_AUIPC:    begin legal = 1'b1; imm = imm_u; src_imm = 1'b1; src_pc = 1'b1; rw = 1'b1; end
      OPC_JAL:      begin legal = 1'b1; imm = imm_j; src_imm = 1'b1; src_pc = 1'b1; rw = 1'b1; jp = 1'b1; end
      OPC_JALR:     begin legal = (f3 == 3'b000); imm = imm_i; src_imm = 1'b1; rw = 1'b1; jp = 1'b1; end
      OPC_BRANCH:   begin legal = (f3 != 3'b010) && (f3 != 3'b011); imm = imm_b; alu_op = ALU_SUB; br = 1'b1; end
      OPC_LOAD:     begin legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                          imm = imm_i; src_imm = 1'b1; rw = 1'b1; mr = 1'b1; end
      OPC_STORE:    begin legal = (f3 <= 3'b010); imm = imm_s; src_imm = 1'b1; mw = 1'b1; end
      OPC_OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        // inst[30] only selects SRAI; ADDI ignores it.
        alu_op  = alu_of(f3, (f3 == 3'b101) && f7[5]);
        imm     = imm_i;
        src_imm = 1'b1;
        rw      = 1'b1;
      end
      OPC_OP: begin
        rw = 1'b1;
        if (f7 == 7'b0000000) begin
          legal  = 1'b1;
          alu_op = alu_of(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          legal  = (f3 == 3'b000) || (f3 == 3'b101);
          alu_op = alu_of(f3, 1'b1);
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          legal  = 1'b1;
          alu_op = {2'b10, f3};
        end
`endif
      end
      OPC_MISC_MEM: begin legal = 1'b1; imm = imm_i; end
      OPC_SYSTEM:   begin legal = 1'b1; imm = imm_i; end
      default:      ;
    endcase
  end

  // Assemble the bundle; illegal words keep their fields but lose all effects.
  always_comb begin
    dec             = '0;
    dec.pc          = in_pc;
    dec.rd          = in_instruction[11:7];
    dec.rs1         = in_instruction[19:15];
    dec.rs2         = in_instruction[24:20];
    dec.funct3      = f3;
    dec.illegal     = !legal;
    if (legal) begin
      dec.imm         = imm;
      dec.alu_op      = alu_op;
      dec.alu_src_imm = src_imm;
      dec.alu_src_pc  = src_pc;
      dec.reg_write   = rw && (in_instruction[11:7] != 5'd0);
      dec.mem_read    = mr;
      dec.mem_write   = mw;
      dec.branch      = br;
      dec.jump        = jp;
    end
  end

  assign in_ready = !valid_q || out_ready || flush;
  assign accept   = in_valid && in_ready && !flush;

  // Output register control: flush wins, then accept, then drain.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (accept) bundle_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = bundle_q.pc;
  assign out_rd          = bundle_q.rd;
  assign out_rs1         = bundle_q.rs1;
  assign out_rs2         = bundle_q.rs2;
  assign out_funct3      = bundle_q.funct3;
  assign out_imm         = bundle_q.imm;
  assign out_alu_op      = bundle_q.alu_op;
  assign out_alu_src_imm = bundle_q.alu_src_imm;
  assign out_alu_src_pc  = bundle_q.alu_src_pc;
  assign out_reg_write   = bundle_q.reg_write;
  assign out_mem_read    = bundle_q.mem_read;
  assign out_mem_write   = bundle_q.mem_write;
  assign out_branch      = bundle_q.branch;
  assign out_jump        = bundle_q.jump;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage between instruction fetch and execute. It accepts one fetched instruction word plus PC per valid/ready handshake and fully decodes it: register indices, sign-extended immediate, ALU operation, control flags and an illegal-instruction flag. Results are held in a single output pipeline register with back-pressure and flush. It supersedes the combinational decode unit as the pipeline's decode stage.

## Interface
- XLEN, 32: datapath width for `pc` and `imm` (32 or 64); instruction width fixed at 32.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard held and incoming instruction (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instruction  in  32  instruction word.
- in_pc  in  XLEN  PC of instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices (inst[11:7], [19:15], [24:20]).
- out_funct3  out  3  inst[14:12].
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  5  ALU operation code.
- out_alu_src_imm  out  1  operand B is immediate.
- out_alu_src_pc  out  1  operand A is PC (AUIPC, JAL).
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  control flags.
- out_illegal  out  1  instruction not legal.

## Operation
- in_ready = !out_valid | out_ready | flush (combinational).
- Accept when in_valid & in_ready; decode is combinational on the input, then captured in the output register.
- Bundle holds stable while out_valid & !out_ready.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (f3=000), BRANCH 1100011 (f3≠010/011), LOAD 0000011 (f3∈000,001,010,100,101), STORE 0100011 (f3≤010), OP-IMM 0010011 (SLLI f7=0; SRLI/SRAI f7∈0,0100000), OP 0110011 (f7=0; f7=0100000 only for ADD/SUB, SRL/SRA), MISC-MEM 0001111, SYSTEM 1110011. Everything else, including inst[1:0]≠11, is illegal.
- Immediates: I [31:20], S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, U {[31:12],12'b0}, J {[31],[19:12],[20],[30:21],0}; all sign-extended from inst[31] to XLEN. R-type imm = 0.
- alu_op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10 (LUI); loads/stores/JAL/JALR/AUIPC use ADD; branches use SUB.
- reg_write forced 0 when rd = 0, and for BRANCH, STORE, MISC-MEM, SYSTEM.
- Illegal instruction is still passed downstream: out_illegal = 1, all of reg_write/mem_read/mem_write/branch/jump = 0, alu_op = 0.

## Timing
- Latency 1 cycle: accepted on edge N, out_valid high after edge N.
- Throughput 1 instruction/cycle with out_ready held high.
- Accept and drain in the same cycle: new bundle replaces old, out_valid stays 1.
- Drain without accept: out_valid → 0.
- flush: out_valid → 0 on next edge regardless of out_ready; input accepted during flush is dropped.
- Reset (any time, async): out_valid = 0 and every out_* field = 0; in-flight bundle lost; in_ready = 1 while rst is high.

## Configuration
- DECODE_RV32M_EN defined: OP with f7=0000001 is legal; alu_op = 16 + f3 (MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23), reg_write per rd rule.
- Undefined: f7=0000001 on OP → out_illegal = 1.

## Test plan
- Reset, then 0x00106093 (ori x1,x0,1) with out_ready=1 → one cycle later out_valid=1, rd=1, rs1=0, imm=1, alu_op=8, alu_src_imm=1, reg_write=1.
- 0x00418063 (beq x3,x4,0) then 0x00102023 (sw x1,0(x0)) back-to-back → branch=1/alu_op=1/reg_write=0, then mem_write=1/rs2=1/imm=0; no bubble between them.
- Hold out_ready=0 two cycles with 0x00106093 held and 0x00418063 pending → bundle stable, in_ready=0; release → ori drains, beq captured next edge.
- 0x00000000 and 0x0000A0B3 (f3=010, f7=0 → SLT, legal) → first out_illegal=1 and all flags 0; second illegal=0, alu_op=3.
- 0x022080B3 (mul x1,x1,x2) → with DECODE_RV32M_EN alu_op=16, reg_write=1; without, out_illegal=1.
- flush with out_valid=1, out_ready=0, in_valid=1 → next cycle out_valid=0; assert rst mid-stream → all outputs 0 immediately.
